// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states, lane masks.
// No logic of its own; imported by load_store_unit and lsu_lane_align.
// Lane masks are byte-granular over a 64-bit RAM word.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m << {off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts/extends load data and merges sub-dword store data into a word.
// Purely combinational, zero latency.
// No handshake; consumed by the load_store_unit FSM.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        size,
  input  logic [2:0]        off,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] old_q,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  assign shifted = old_q >> {off, 3'b000};
  assign mask    = DATA_W'(lane_mask(size, off));
  assign merged  = (old_q & ~mask) | ((wdata << {off, 3'b000}) & mask);

  always_comb begin
    load_data = shifted;
    case (size)
      SZ_B: load_data = {{(DATA_W-8){sign_ext & shifted[7]}},   shifted[7:0]};
      SZ_H: load_data = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_W: load_data = {{(DATA_W-32){sign_ext & shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage driving a 64-bit word RAM; sub-dword stores use read-modify-write.
// Latency accept->resp: load 2, dword store 2, sub-dword store 3, error 1 (LSU_ALIGN_CHECK_EN: misalign errors).
// req_ready high only when idle; resp is a one-cycle pulse with no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int RAM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [63:0]       ram_address,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_out
);

  lsu_state_t        state, state_nxt;
  logic              r_write, r_signed, r_err;
  logic [1:0]        r_size;
  logic [2:0]        r_off;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_wdata, old_q;
  logic [DATA_W-1:0] load_data, merged;

  logic              accept, range_err, align_err;
  logic [2:0]        low_mask, off_in;
  logic [ADDR_W-1:0] idx_in;

  assign accept   = req_valid && req_ready;
  assign low_mask = 3'((4'd1 << req_size) - 4'd1);
  assign idx_in   = req_addr >> 3;
  assign range_err = idx_in >= ADDR_W'(RAM_DEPTH);

`ifdef LSU_ALIGN_CHECK_EN
  assign align_err = |(req_addr[2:0] & low_mask);
  assign off_in    = req_addr[2:0];
`else
  // Silent align-down keeps every access inside one RAM word.
  assign align_err = 1'b0;
  assign off_in    = req_addr[2:0] & ~low_mask;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (range_err || align_err)            state_nxt = ST_RESP;
          else if (!req_write || req_size != SZ_D) state_nxt = ST_READ;
          else                                   state_nxt = ST_WRITE;
        end
      end
      ST_READ:  state_nxt = r_write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= SZ_B;
      r_off    <= 3'd0;
      r_idx    <= '0;
      r_wdata  <= '0;
      old_q    <= '0;
    end else begin
      if (accept) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_err    <= range_err || align_err;
        r_size   <= req_size;
        r_off    <= off_in;
        r_idx    <= idx_in;
        r_wdata  <= req_wdata;
      end
      if (state == ST_READ) old_q <= ram_out;
    end
  end

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (r_size),
    .off       (r_off),
    .sign_ext  (r_signed),
    .old_q     (old_q),
    .wdata     (r_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // RAM pins decode from state alone so an async reset drops the enables at once.
  assign ram_read_en  = (state == ST_READ);
  assign ram_write_en = (state == ST_WRITE);
  assign ram_address  = (ram_read_en || ram_write_en) ? 64'(r_idx) : 64'd0;
  assign ram_data_in  = ram_write_en ? ((r_size == SZ_D) ? r_wdata : merged) : '0;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_err && !r_write) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 32-word RAM and a response scoreboard.
// Expected responses (data, error, latency, enable counts) are queued at issue and checked by a monitor.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] ram_address;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [63:0] ram_data_in;
  logic [63:0] ram_out;

  logic [63:0] mem [32];

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          rd;
    int          wr;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ram_out = (ram_address < 64'd32) ? mem[ram_address[4:0]] : 64'd0;
  always @(posedge clk) begin
    if (ram_write_en && ram_address < 64'd32) mem[ram_address[4:0]] <= ram_data_in;
  end

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_address  (ram_address),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_data_in  (ram_data_in),
    .ram_out      (ram_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: counts RAM enables per transaction and scores each response.
  initial begin
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (ram_read_en)  rd_cnt++;
        if (ram_write_en) wr_cnt++;
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 64'(resp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_err",   64'(resp_err), 64'(e.err));
            check("resp_rdata", resp_rdata, e.rdata);
            check("latency",    64'(cyc - e.t0), 64'(e.lat));
            check("read_en_cycles",  64'(rd_cnt), 64'(e.rd));
            check("write_en_cycles", 64'(wr_cnt), 64'(e.wr));
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic e_err, input logic [63:0] e_rd,
                       input int lat, input int rd, input int wr, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_at_issue", 64'(req_ready), 64'd1);
    if (push) begin
      e.err = e_err; e.rdata = e_rd; e.lat = lat; e.rd = rd; e.wr = wr; e.t0 = cyc;
      exp_q.push_back(e);
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (push) begin
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) begin
        check("resp_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_req_ready",  64'(req_ready), 64'd1);
    check("rst_resp",       {61'd0, resp_valid, resp_err, |resp_rdata}, 64'd0);
    check("rst_ram_en",     {62'd0, ram_read_en, ram_write_en}, 64'd0);
    check("rst_ram_addr",   ram_address, 64'd0);
    check("rst_ram_data",   ram_data_in, 64'd0);
    rst_n = 1'b1;

    // dword store then load
    issue(1, SZ_D, 0, 64'h10, 64'h1122334455667788, 0, 64'd0, 2, 0, 1, 1);
    issue(0, SZ_D, 0, 64'h10, 64'd0, 0, 64'h1122334455667788, 2, 1, 0, 1);
    // byte read-modify-write store
    issue(1, SZ_B, 0, 64'h13, 64'hAB, 0, 64'd0, 3, 1, 1, 1);
    issue(0, SZ_D, 0, 64'h10, 64'd0, 0, 64'h11223344AB667788, 2, 1, 0, 1);
    issue(0, SZ_B, 1, 64'h13, 64'd0, 0, 64'hFFFFFFFFFFFFFFAB, 2, 1, 0, 1);
    issue(0, SZ_H, 0, 64'h16, 64'd0, 0, 64'h0000000000001122, 2, 1, 0, 1);
    // word sign/zero extension
    issue(1, SZ_D, 0, 64'h18, 64'h0000000080000000, 0, 64'd0, 2, 0, 1, 1);
    issue(0, SZ_W, 1, 64'h18, 64'd0, 0, 64'hFFFFFFFF80000000, 2, 1, 0, 1);
    issue(0, SZ_W, 0, 64'h18, 64'd0, 0, 64'h0000000080000000, 2, 1, 0, 1);
    // out of range, and the last valid word
    issue(0, SZ_D, 0, 64'h100, 64'd0, 1, 64'd0, 1, 0, 0, 1);
    issue(1, SZ_B, 0, 64'h100, 64'hFF, 1, 64'd0, 1, 0, 0, 1);
    issue(1, SZ_D, 0, 64'hF8, 64'hCAFEF00DDEADBEEF, 0, 64'd0, 2, 0, 1, 1);
    issue(0, SZ_D, 0, 64'hF8, 64'd0, 0, 64'hCAFEF00DDEADBEEF, 2, 1, 0, 1);
    // misaligned accesses
    issue(1, SZ_D, 0, 64'h20, 64'd0, 0, 64'd0, 2, 0, 1, 1);
`ifdef LSU_ALIGN_CHECK_EN
    issue(1, SZ_H, 0, 64'h21, 64'hBEEF, 1, 64'd0, 1, 0, 0, 1);
    issue(0, SZ_D, 0, 64'h20, 64'd0, 0, 64'd0, 2, 1, 0, 1);
    issue(0, SZ_W, 0, 64'h1B, 64'd0, 1, 64'd0, 1, 0, 0, 1);
`else
    issue(1, SZ_H, 0, 64'h21, 64'hBEEF, 0, 64'd0, 3, 1, 1, 1);
    issue(0, SZ_D, 0, 64'h20, 64'd0, 0, 64'h000000000000BEEF, 2, 1, 0, 1);
    issue(0, SZ_W, 0, 64'h1B, 64'd0, 0, 64'h0000000080000000, 2, 1, 0, 1);
`endif

    // reset during the write cycle of a sub-dword store
    issue(1, SZ_B, 0, 64'h08, 64'h55, 0, 64'd0, 0, 0, 0, 0);
    n = 0;
    while (!ram_write_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reached_write", 64'(ram_write_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_en", {62'd0, ram_read_en, ram_write_en}, 64'd0);
    check("rst_no_resp",  64'(resp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {62'd0, req_ready, resp_valid}, 64'd2);
    end
    issue(0, SZ_D, 0, 64'h10, 64'd0, 0, 64'h11223344AB667788, 2, 1, 0, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
